mem_access_arbiter: RTL and testbench



---
 rtl/mem_access_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_access_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Arbiter sequencing a single-port unified memory between instruction fetch and data load/store.
// One transaction in flight: IDLE (grant) -> ACCESS (memory cycle) -> RESP (done pulse).
module mem_access_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              sel_f_q, sel_f_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              fetch_wins;

    // Handshake: req is a level sampled only in IDLE; ack marks the ACCESS cycle, done the RESP
    // cycle, and a req still high in the next IDLE cycle starts a new transaction.
    assign fetch_wins = f_req && (!d_req || (starve_q == STARVE_LIM));

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        sel_f_d   = sel_f_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (f_req || d_req) begin
                    state_d = ACCESS;
                    sel_f_d = fetch_wins;
                    if (fetch_wins) begin
                        addr_d   = f_addr;
                        we_d     = 1'b0;
                        starve_d = 4'd0;
                    end else begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        // Only a data grant that overtakes a waiting fetch counts toward starvation.
                        if (!f_req)
                            starve_d = 4'd0;
                        else if (starve_q != STARVE_LIM)
                            starve_d = starve_q + 4'd1;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) begin
                    if (sel_f_q) f_rdata_d = mem_rdata;
                    else         d_rdata_d = mem_rdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            starve_q  <= 4'd0;
            sel_f_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            sel_f_q   <= sel_f_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign f_ack     = (state_q == ACCESS) && sel_f_q;
    assign d_ack     = (state_q == ACCESS) && !sel_f_q;
    assign f_done    = (state_q == RESP) && sel_f_q;
    assign d_done    = (state_q == RESP) && !sel_f_q;
    assign busy      = (state_q != IDLE);
    // Gated by rst so a reset during ACCESS suppresses the pending write.
    assign mem_we    = (state_q == ACCESS) && we_q && !rst;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural memory and a done-ordered scoreboard.
module tb_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_ack, f_done;
    logic [11:0] f_addr;
    logic [15:0] f_rdata;
    logic        d_req, d_we, d_ack, d_done;
    logic [11:0] d_addr;
    logic [15:0] d_wdata, d_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata, mem_rdata;
    logic        busy;

    logic [15:0] mem [4096];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [15:0] pre_data;

    // Entry: {is_fetch, expected rdata of that port at done}
    logic [16:0] exp_q[$];
    logic [15:0] exp_f, exp_d;
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_access_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)      mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_f, input logic [15:0] data);
        exp_q.push_back({is_f, data});
    endtask

    // Scoreboard and exclusivity monitor.
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst) begin
            chk("one_ack", {31'd0, f_ack & d_ack}, 32'd0);
            chk("one_done", {31'd0, f_done & d_done}, 32'd0);
            if (f_done || d_done) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", {30'd0, f_done, d_done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_port", {31'd0, f_done}, {31'd0, e[16]});
                    chk("sb_rdata", {16'd0, (f_done ? f_rdata : d_rdata)}, {16'd0, e[15:0]});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        exp_f = '0; exp_d = '0;

        // Preload memory while held in reset.
        pre_we = 1'b1;
        pre_addr = 12'h010; pre_data = 16'hA5A5; cycle();
        pre_addr = 12'h020; pre_data = 16'h1111; cycle();
        pre_addr = 12'h001; pre_data = 16'h0101; cycle();
        pre_addr = 12'h002; pre_data = 16'h0202; cycle();
        pre_addr = 12'h100; pre_data = 16'h0000; cycle();
        pre_addr = 12'hFFF; pre_data = 16'h0000; cycle();
        pre_we = 1'b0;

        // Reset held two cycles with both requests high.
        f_req = 1'b1; d_req = 1'b1; f_addr = 12'h010; d_addr = 12'h020;
        cycle(); cycle();
        @(negedge clk);
        chk("rst_ctrl", {26'd0, f_ack, d_ack, f_done, d_done, busy, mem_we}, 32'd0);
        chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_f_rdata", {16'd0, f_rdata}, 32'd0);
        chk("rst_d_rdata", {16'd0, d_rdata}, 32'd0);
        exp_d = 16'h1111; push(1'b0, exp_d);
        rst = 1'b0;
        cycle();
        @(negedge clk);
        chk("first_ack_data", {30'd0, d_ack, f_ack}, 32'd2);
        chk("busy_access", {31'd0, busy}, 32'd1);
        f_req = 1'b0; d_req = 1'b0;
        cycle(); cycle();

        // Single fetch.
        f_req = 1'b1; f_addr = 12'h010;
        exp_f = 16'hA5A5; push(1'b1, exp_f);
        cycle();
        @(negedge clk);
        chk("fetch_ack", {30'd0, f_ack, d_ack}, 32'd2);
        f_req = 1'b0;
        cycle();
        @(negedge clk);
        chk("fetch_done", {29'd0, f_done, d_ack, d_done}, 32'd4);
        chk("fetch_rdata", {16'd0, f_rdata}, 32'h0000A5A5);
        cycle();
        chk("idle_after_fetch", {31'd0, busy}, 32'd0);

        // Write 0x1234 to 0xFFF, then read it back in the next IDLE cycle.
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'hFFF; d_wdata = 16'h1234;
        push(1'b0, exp_d);
        cycle();
        @(negedge clk);
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_addr", {20'd0, mem_addr}, 32'h00000FFF);
        chk("wr_mem_wdata", {16'd0, mem_wdata}, 32'h00001234);
        d_req = 1'b0;
        cycle();
        @(negedge clk);
        chk("wr_we_resp", {31'd0, mem_we}, 32'd0);
        cycle();
        chk("wr_we_idle", {31'd0, mem_we}, 32'd0);
        chk("wr_landed", {16'd0, mem[12'hFFF]}, 32'h00001234);
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'hFFF;
        exp_d = 16'h1234; push(1'b0, exp_d);
        cycle();
        d_req = 1'b0;
        cycle(); cycle();

        // Simultaneous requests: data first, then fetch.
        f_req = 1'b1; f_addr = 12'h001; d_req = 1'b1; d_addr = 12'h002; d_we = 1'b0;
        exp_d = 16'h0202; push(1'b0, exp_d);
        exp_f = 16'h0101; push(1'b1, exp_f);
        cycle();
        @(negedge clk);
        chk("sim_first_data", {30'd0, d_ack, f_ack}, 32'd2);
        d_req = 1'b0;
        cycle(); cycle(); cycle();
        @(negedge clk);
        chk("sim_second_fetch", {30'd0, f_ack, d_ack}, 32'd2);
        f_req = 1'b0;
        cycle(); cycle();
        chk("sim_six_cycles", {31'd0, busy}, 32'd0);

        // Starvation guard: four data grants, then a forced fetch, repeated.
        f_req = 1'b1; d_req = 1'b1; f_addr = 12'h001; d_addr = 12'h002; d_we = 1'b0;
        for (int g = 0; g < 10; g++) begin
            if (g == 4 || g == 9) push(1'b1, exp_f);
            else                  push(1'b0, exp_d);
            cycle();
            @(negedge clk);
            chk($sformatf("starve_grant%0d", g), {30'd0, f_ack, d_ack},
                (g == 4 || g == 9) ? 32'd2 : 32'd1);
            cycle(); cycle();
        end
        f_req = 1'b0; d_req = 1'b0;
        cycle();

        // Reset during ACCESS of a write: no write, no done, back to IDLE.
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h100; d_wdata = 16'hBEEF;
        cycle();
        @(negedge clk);
        chk("rstmid_ack", {31'd0, d_ack}, 32'd1);
        chk("rstmid_we_pre", {31'd0, mem_we}, 32'd1);
        rst = 1'b1; d_req = 1'b0;
        #1;
        chk("rstmid_we_gated", {31'd0, mem_we}, 32'd0);
        cycle();
        rst = 1'b0;
        exp_f = '0; exp_d = '0;
        @(negedge clk);
        chk("rstmid_idle", {30'd0, busy, d_done}, 32'd0);
        chk("rstmid_rdata", {f_rdata, d_rdata}, 32'd0);
        chk("rstmid_no_write", {16'd0, mem[12'h100]}, 32'd0);
        cycle();
        @(negedge clk);
        chk("rstmid_no_done", {30'd0, busy, d_done}, 32'd0);

        cycle(); cycle();
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
